// File: rtl/or1200_lsu_pad_arbiter.sv
// rtl/or1200_lsu_pad_arbiter.sv - shares one multi-cycle pad core between LSU and IF requesters
module or1200_lsu_pad_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    output logic        lsu_ack,
    output logic [31:0] lsu_pad,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_pad,
    input  logic        flush,
    input  logic        cfg_ctr_we,
    input  logic [31:0] cfg_ctr,
    input  logic        cfg_clr_err,
    output logic        core_start,
    output logic [31:0] core_addr,
    output logic [31:0] core_ctr,
    input  logic        core_done,
    input  logic [31:0] core_pad,
    output logic        pad_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic            grant_if;
    logic            last_if;
    logic            discard;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     ctr;
    logic            pick_if;
    logic            to_hit;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_if = (lsu_req && if_req) ? !last_if : if_req;
    end

    assign to_hit = (state == S_WAIT) && !core_done &&
                    ((to_cnt + 1'b1) == TO_W'(TIMEOUT - 1));

    // Acks see the live req/flush so a dropped request or a late flush suppresses them.
    assign lsu_ack = (state == S_RESP) && !grant_if && lsu_req && !discard && !flush;
    assign if_ack  = (state == S_RESP) &&  grant_if && if_req  && !discard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant_if   <= 1'b0;
            last_if    <= 1'b1;
            discard    <= 1'b0;
            to_cnt     <= '0;
            ctr        <= '0;
            lsu_pad    <= '0;
            if_pad     <= '0;
            core_start <= 1'b0;
            core_addr  <= '0;
            core_ctr   <= '0;
            pad_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (cfg_ctr_we)
                ctr <= cfg_ctr;
            if (to_hit)
                pad_err <= 1'b1;
            else if (cfg_clr_err)
                pad_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!pad_err && !flush && (lsu_req || if_req)) begin
                        grant_if   <= pick_if;
                        core_addr  <= pick_if ? if_addr : lsu_addr;
                        core_ctr   <= ctr;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    if (flush)
                        discard <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (flush)
                        discard <= 1'b1;
                    if (core_done) begin
                        if (grant_if)
                            if_pad <= core_pad;
                        else
                            lsu_pad <= core_pad;
                        state <= S_RESP;
                    end else if (to_hit) begin
                        discard <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    last_if <= grant_if;
                    discard <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_or1200_lsu_pad_arbiter.sv
// tb/tb_or1200_lsu_pad_arbiter.sv - directed bench with a transaction-level reference model
module tb_or1200_lsu_pad_arbiter;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_ack;
    logic [31:0] lsu_pad;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_pad;
    logic        flush = 1'b0;
    logic        cfg_ctr_we = 1'b0;
    logic [31:0] cfg_ctr = '0;
    logic        cfg_clr_err = 1'b0;
    logic        core_start;
    logic [31:0] core_addr;
    logic [31:0] core_ctr;
    logic        core_done = 1'b0;
    logic [31:0] core_pad = '0;
    logic        pad_err;
    logic        busy;

    or1200_lsu_pad_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_ack(lsu_ack), .lsu_pad(lsu_pad),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_pad(if_pad),
        .flush(flush), .cfg_ctr_we(cfg_ctr_we), .cfg_ctr(cfg_ctr), .cfg_clr_err(cfg_clr_err),
        .core_start(core_start), .core_addr(core_addr), .core_ctr(core_ctr),
        .core_done(core_done), .core_pad(core_pad), .pad_err(pad_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, tracked by its age since grant.
    bit          m_act = 0, m_who = 0, m_resp = 0, m_disc = 0, m_last = 1, m_err = 0, m_to = 0;
    int          m_age = 0;
    logic [31:0] m_addr = '0, m_snap = '0, m_ctr = '0;
    logic [31:0] m_pad [2] = '{32'h0, 32'h0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_who = 0; m_resp = 0; m_disc = 0; m_last = 1; m_err = 0;
            m_age = 0; m_addr = '0; m_snap = '0; m_ctr = '0;
            m_pad[0] = '0; m_pad[1] = '0;
        end else begin
            m_to = 0;
            if (!m_act) begin
                if (!m_err && !flush && (lsu_req || if_req)) begin
                    m_who  = (lsu_req && if_req) ? !m_last : if_req;
                    m_addr = m_who ? if_addr : lsu_addr;
                    m_snap = m_ctr;
                    m_act  = 1; m_age = 1; m_resp = 0;
                end
            end else if (m_resp) begin
                m_last = m_who; m_disc = 0; m_act = 0;
            end else begin
                if (flush) m_disc = 1;
                if (m_age >= 2 && core_done) begin
                    m_pad[m_who] = core_pad;
                    m_resp = 1;
                end else if (m_age - 1 == TIMEOUT - 1) begin
                    m_to = 1; m_act = 0; m_disc = 0;
                end else begin
                    m_age++;
                end
            end
            if (m_to) m_err = 1;
            else if (cfg_clr_err) m_err = 0;
            if (cfg_ctr_we) m_ctr = cfg_ctr;
        end
    end

    int start_cyc = 0, lsu_ack_cyc = 0, n_start = 0, n_lsu_ack = 0;
    bit lsu_ack_q = 0, if_ack_q = 0;
    bit ack_log[$];

    always @(negedge clk) begin
        logic exp_la, exp_ia;
        exp_la = m_act && m_resp && !m_who && lsu_req && !m_disc && !flush;
        exp_ia = m_act && m_resp &&  m_who && if_req  && !m_disc && !flush;
        chk("busy", busy, m_act);
        chk("core_start", core_start, m_act && m_age == 1);
        chk("lsu_ack", lsu_ack, exp_la);
        chk("if_ack", if_ack, exp_ia);
        chk("lsu_pad", lsu_pad, m_pad[0]);
        chk("if_pad", if_pad, m_pad[1]);
        chk("core_addr", core_addr, m_addr);
        chk("core_ctr", core_ctr, m_snap);
        chk("pad_err", pad_err, m_err);
        if (core_start) begin start_cyc = cyc; n_start++; end
        if (lsu_ack) begin lsu_ack_cyc = cyc; n_lsu_ack++; ack_log.push_back(1'b0); end
        if (if_ack) ack_log.push_back(1'b1);
        lsu_ack_q = lsu_ack;
        if_ack_q  = if_ack;
    end

    // Requesters hold req until acked, drop it for one cycle, then re-request while work remains.
    int lsu_todo = 0, if_todo = 0, lsu_rise = 0;
    always begin
        @(posedge clk); #1;
        if (lsu_req && lsu_ack_q) lsu_req = 1'b0;
        else if (!lsu_req && lsu_todo > 0 && !rst) begin lsu_req = 1'b1; lsu_todo--; lsu_rise = cyc; end
        if (if_req && if_ack_q) if_req = 1'b0;
        else if (!if_req && if_todo > 0 && !rst) begin if_req = 1'b1; if_todo--; end
    end

    // Pad core stand-in: answers rsp_delay cycles after core_start (0 = never).
    int          rsp_delay = 0, rsp_cnt = -1;
    logic [31:0] rsp_pad = '0;
    always begin
        @(posedge clk); #1;
        core_done = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin core_done = 1'b1; core_pad = rsp_pad; rsp_cnt = -1; end
        end else if (core_start && rsp_delay > 0) begin
            rsp_cnt = rsp_delay;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic settle(input string name, input int max);
        int k = 0;
        while ((lsu_todo > 0 || if_todo > 0 || lsu_req || if_req || busy) && k < max) begin
            step(); k++;
        end
        n_tests++;
        if (k >= max) begin n_fail++; $display("FAIL %s: traffic not drained after %0d cycles", name, max); end
    endtask

    task automatic wait_start(input string name, input int max);
        int base = n_start;
        int k = 0;
        while (n_start == base && k < max) begin step(); k++; end
        n_tests++;
        if (n_start == base) begin n_fail++; $display("FAIL %s: no core_start within %0d cycles", name, max); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lsu_todo = 0; if_todo = 0; lsu_req = 1'b0; if_req = 1'b0; rsp_cnt = -1;
        step(2);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_ack, base_start, s, k, c;
        bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        step(3);
        rst = 1'b0;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_lsu_pad", lsu_pad, 0);
        chk("reset_pad_err", pad_err, 0);

        // LSU alone, core answers one cycle after start
        lsu_addr = 32'h0000_1000; rsp_delay = 1; rsp_pad = 32'hA5A5_5A5A; lsu_todo = 1;
        settle("t1_settle", 20);
        chk("t1_start_latency", start_cyc - lsu_rise, 1);
        chk("t1_ack_latency", lsu_ack_cyc - lsu_rise, 3);
        chk("t1_lsu_pad", lsu_pad, 32'hA5A5_5A5A);
        chk("t1_if_pad", if_pad, 32'h0);
        chk("t1_core_addr", core_addr, 32'h0000_1000);

        // Both requesting from reset: LSU first, then alternation
        do_reset();
        lsu_addr = 32'h2000; if_addr = 32'h3000; rsp_pad = 32'h1111_0000;
        ack_log.delete();
        lsu_todo = 2; if_todo = 2;
        settle("t2_settle", 80);
        chk("t2_ack_count", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            chk($sformatf("t2_order_%0d", i), ack_log[i], exp_order[i]);
        chk("t2_if_pad", if_pad, 32'h1111_0000);

        // Session counter snapshot vs. a write during WAIT
        do_reset();
        cfg_ctr = 32'h7; cfg_ctr_we = 1'b1; step(); cfg_ctr_we = 1'b0;
        rsp_delay = 5; lsu_addr = 32'h4000; lsu_todo = 1;
        wait_start("t3_start", 10);
        cfg_ctr = 32'h8; cfg_ctr_we = 1'b1; step(); cfg_ctr_we = 1'b0;
        chk("t3_ctr_mid", core_ctr, 32'h7);
        settle("t3_settle_a", 20);
        chk("t3_ctr_held", core_ctr, 32'h7);
        rsp_delay = 1; lsu_todo = 1;
        settle("t3_settle_b", 20);
        chk("t3_ctr_next", core_ctr, 32'h8);

        // Flush during WAIT: pad updates, no ack, requester gets a fresh transaction
        rsp_delay = 4; rsp_pad = 32'hDEAD_BEEF; lsu_addr = 32'h4400; lsu_todo = 1;
        base_ack = n_lsu_ack; base_start = n_start;
        wait_start("t4_start", 10);
        flush = 1'b1; step(); flush = 1'b0;
        step(3);
        chk("t4_no_ack", lsu_ack, 0);
        chk("t4_pad_updated", lsu_pad, 32'hDEAD_BEEF);
        rsp_pad = 32'h0BAD_F00D;
        settle("t4_settle", 30);
        chk("t4_ack_count", n_lsu_ack - base_ack, 1);
        chk("t4_start_count", n_start - base_start, 2);
        chk("t4_final_pad", lsu_pad, 32'h0BAD_F00D);

        // Lost core_done: sticky error, grants blocked until cleared
        rsp_delay = 0; lsu_addr = 32'h5000; lsu_todo = 1;
        base_ack = n_lsu_ack; base_start = n_start;
        wait_start("t5_start", 10);
        s = start_cyc; k = 0;
        while (!pad_err && k < 100) begin step(); k++; end
        chk("t5_err_cycle", cyc - s, 64);
        chk("t5_no_ack", n_lsu_ack - base_ack, 0);
        chk("t5_pad_kept", lsu_pad, 32'h0BAD_F00D);
        step(5);
        chk("t5_blocked_busy", busy, 0);
        chk("t5_blocked_starts", n_start - base_start, 1);
        rsp_delay = 1; rsp_pad = 32'h600D_CAFE;
        cfg_clr_err = 1'b1; c = cyc; step(); cfg_clr_err = 1'b0;
        chk("t5_err_cleared", pad_err, 0);
        settle("t5_settle", 20);
        chk("t5_regrant_cycle", start_cyc - c, 2);
        chk("t5_regrant_pad", lsu_pad, 32'h600D_CAFE);

        // Reset in the middle of WAIT, then a stray core_done
        rsp_delay = 0; lsu_todo = 1;
        wait_start("t6_start", 10);
        step();
        rst = 1'b1; #1;
        chk("t6_busy", busy, 0);
        chk("t6_lsu_pad", lsu_pad, 0);
        chk("t6_core_addr", core_addr, 0);
        chk("t6_pad_err", pad_err, 0);
        lsu_todo = 0; lsu_req = 1'b0;
        base_start = n_start;
        step();
        rst = 1'b0;
        rsp_pad = 32'hFFFF_0001; rsp_cnt = 1;
        step(4);
        chk("t6_late_busy", busy, 0);
        chk("t6_late_pad", lsu_pad, 0);
        chk("t6_late_starts", n_start - base_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
